// File: rtl/boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : boot_sequencer
// Purpose  : Streams instruction/data images into each mesh processor in turn,
//            then releases the mesh from reset.
// Revision : 1.0  initial release
// ============================================================================
module boot_sequencer #(
  parameter int NUM_PROC   = 9,
  parameter int IMEM_WORDS = 4096,
  parameter int DMEM_WORDS = 4096,
  parameter int IDLE_SEL   = 9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [3:0]  processor_select,
  output logic [13:0] boot_iaddr,
  output logic [31:0] boot_idata,
  output logic [13:0] boot_daddr,
  output logic [31:0] boot_ddata,
  output logic        sys_resetn,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_LOAD_I  = 3'd2,
    S_LOAD_D  = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [3:0]  C_SEL_IDLE  = 4'(IDLE_SEL);
  localparam logic [3:0]  C_LAST_PROC = 4'(NUM_PROC - 1);
  localparam logic [13:0] C_I_LAST    = 14'(IMEM_WORDS - 1);
  localparam logic [13:0] C_D_LAST    = 14'(DMEM_WORDS - 1);
  localparam logic [13:0] C_REL_LAST  = 14'd1;

  state_t      state_q;
  logic [3:0]  proc_q;
  logic [13:0] cnt_q;
  logic        in_ready_q;
  logic [3:0]  sel_q;
  logic [13:0] iaddr_q;
  logic [31:0] idata_q;
  logic [13:0] daddr_q;
  logic [31:0] ddata_q;
  logic        sys_resetn_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      proc_q       <= 4'd0;
      cnt_q        <= 14'd0;
      in_ready_q   <= 1'b0;
      sel_q        <= C_SEL_IDLE;
      iaddr_q      <= 14'd0;
      idata_q      <= 32'd0;
      daddr_q      <= 14'd0;
      ddata_q      <= 32'd0;
      sys_resetn_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (abort && busy_q) begin
      // Abort beats acceptance: any word offered this cycle is dropped.
      state_q      <= S_IDLE;
      proc_q       <= 4'd0;
      cnt_q        <= 14'd0;
      in_ready_q   <= 1'b0;
      sel_q        <= C_SEL_IDLE;
      sys_resetn_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_SETUP;
            proc_q       <= 4'd0;
            cnt_q        <= 14'd0;
            sel_q        <= 4'd0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            sys_resetn_q <= 1'b0;
          end
        end

        S_SETUP: begin
          state_q    <= S_LOAD_I;
          cnt_q      <= 14'd0;
          in_ready_q <= 1'b1;
        end

        S_LOAD_I: begin
          if (in_valid) begin
            iaddr_q <= cnt_q;
            idata_q <= in_data;
            if (cnt_q == C_I_LAST) begin
              state_q <= S_LOAD_D;
              cnt_q   <= 14'd0;
            end else begin
              cnt_q <= cnt_q + 14'd1;
            end
          end
        end

        S_LOAD_D: begin
          if (in_valid) begin
            daddr_q <= cnt_q;
            ddata_q <= in_data;
            if (cnt_q == C_D_LAST) begin
              cnt_q      <= 14'd0;
              in_ready_q <= 1'b0;
              if (proc_q < C_LAST_PROC) begin
                proc_q  <= proc_q + 4'd1;
                sel_q   <= proc_q + 4'd1;
                state_q <= S_SETUP;
              end else begin
                sel_q   <= C_SEL_IDLE;
                state_q <= S_RELEASE;
              end
            end else begin
              cnt_q <= cnt_q + 14'd1;
            end
          end
        end

        S_RELEASE: begin
          // Mesh stays in reset for two cycles after the final write.
          if (cnt_q == C_REL_LAST) begin
            state_q      <= S_DONE;
            cnt_q        <= 14'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            sys_resetn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 14'd1;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          proc_q       <= 4'd0;
          cnt_q        <= 14'd0;
          in_ready_q   <= 1'b0;
          sel_q        <= C_SEL_IDLE;
          sys_resetn_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign processor_select = sel_q;
  assign boot_iaddr       = iaddr_q;
  assign boot_idata       = idata_q;
  assign boot_daddr       = daddr_q;
  assign boot_ddata       = ddata_q;
  assign sys_resetn       = sys_resetn_q;
  assign busy             = busy_q;
  assign done             = done_q;

`ifndef SYNTHESIS
  a_ready_implies_busy : assert property (@(posedge clk) disable iff (!resetn)
    in_ready |-> busy);
  a_done_matches_release : assert property (@(posedge clk) disable iff (!resetn)
    done == sys_resetn);
  a_done_not_busy : assert property (@(posedge clk) disable iff (!resetn)
    !(done && busy));
`endif

endmodule
`default_nettype wire

// File: tb/tb_boot_sequencer.sv
`default_nettype none
// Testbench for boot_sequencer: directed vector table, corner-case sequences,
// and randomized traffic checked against an event-queue model of a boot pass.
module tb_boot_sequencer;

  localparam int NP = 2;
  localparam int IW = 4;
  localparam int DW = 2;
  localparam int IS = 9;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [3:0]  processor_select;
  logic [13:0] boot_iaddr;
  logic [31:0] boot_idata;
  logic [13:0] boot_daddr;
  logic [31:0] boot_ddata;
  logic        sys_resetn;
  logic        busy;
  logic        done;

  boot_sequencer #(
    .NUM_PROC  (NP),
    .IMEM_WORDS(IW),
    .DMEM_WORDS(DW),
    .IDLE_SEL  (IS)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .abort           (abort),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .processor_select(processor_select),
    .boot_iaddr      (boot_iaddr),
    .boot_idata      (boot_idata),
    .boot_daddr      (boot_daddr),
    .boot_ddata      (boot_ddata),
    .sys_resetn      (sys_resetn),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model: a boot pass is a list of slots ----------
  // kind 0 = select cycle for proc, 1 = instruction word, 2 = data word,
  // 3 = post-load release cycle. Word slots wait for in_valid, others take 1 cycle.
  typedef struct { int kind; int proc; int addr; } ev_t;
  ev_t         mq[$];
  logic        m_done  = 1'b0;
  logic [13:0] m_ia    = 14'd0;
  logic [31:0] m_id    = 32'd0;
  logic [13:0] m_da    = 14'd0;
  logic [31:0] m_dd    = 32'd0;

  task automatic build_pass();
    ev_t e;
    mq.delete();
    for (int p = 0; p < NP; p++) begin
      e = '{kind: 0, proc: p, addr: 0}; mq.push_back(e);
      for (int k = 0; k < IW; k++) begin e = '{kind: 1, proc: p, addr: k}; mq.push_back(e); end
      for (int k = 0; k < DW; k++) begin e = '{kind: 2, proc: p, addr: k}; mq.push_back(e); end
    end
    e = '{kind: 3, proc: 0, addr: 0};
    mq.push_back(e);
    mq.push_back(e);
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_done = 1'b0;
      m_ia = 14'd0; m_id = 32'd0; m_da = 14'd0; m_dd = 32'd0;
    end else if (mq.size() > 0) begin
      if (abort) begin
        mq.delete();
      end else if (mq[0].kind == 1 || mq[0].kind == 2) begin
        if (in_valid) begin
          if (mq[0].kind == 1) begin m_ia = 14'(mq[0].addr); m_id = in_data; end
          else                 begin m_da = 14'(mq[0].addr); m_dd = in_data; end
          mq.delete(0);
        end
      end else begin
        mq.delete(0);
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else if (start) begin
      m_done = 1'b0;
      build_pass();
    end
  end

  function automatic logic m_busy();
    return mq.size() > 0;
  endfunction
  function automatic logic m_rdy();
    return (mq.size() > 0) && (mq[0].kind == 1 || mq[0].kind == 2);
  endfunction
  function automatic logic [3:0] m_sel();
    if (mq.size() == 0 || mq[0].kind == 3) return 4'(IS);
    return 4'(mq[0].proc);
  endfunction

  task automatic check_model(input string t);
    chk({t, ".sel"},   32'(processor_select), 32'(m_sel()));
    chk({t, ".rdy"},   32'(in_ready),         32'(m_rdy()));
    chk({t, ".busy"},  32'(busy),             32'(m_busy()));
    chk({t, ".done"},  32'(done),             32'(m_done));
    chk({t, ".srn"},   32'(sys_resetn),       32'(m_done));
    chk({t, ".iaddr"}, 32'(boot_iaddr),       32'(m_ia));
    chk({t, ".idata"}, boot_idata,            m_id);
    chk({t, ".daddr"}, 32'(boot_daddr),       32'(m_da));
    chk({t, ".ddata"}, boot_ddata,            m_dd);
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".sel"},   32'(processor_select), 32'(IS));
    chk({t, ".rdy"},   32'(in_ready),         32'd0);
    chk({t, ".busy"},  32'(busy),             32'd0);
    chk({t, ".done"},  32'(done),             32'd0);
    chk({t, ".srn"},   32'(sys_resetn),       32'd0);
    chk({t, ".iaddr"}, 32'(boot_iaddr),       32'd0);
    chk({t, ".idata"}, boot_idata,            32'd0);
    chk({t, ".daddr"}, 32'(boot_daddr),       32'd0);
    chk({t, ".ddata"}, boot_ddata,            32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vector table --------------------------------------
  typedef struct {
    int st, vl, ab;
    int sel, rdy, bsy, dn, srn, ia, da;
  } vec_t;
  vec_t tv[$];

  task automatic add(input int st, vl, ab, sel, rdy, bsy, dn, srn, ia, da);
    vec_t v;
    v = '{st: st, vl: vl, ab: ab, sel: sel, rdy: rdy, bsy: bsy, dn: dn, srn: srn, ia: ia, da: da};
    tv.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [31:0] d1;
    logic [31:0] d0;

    resetn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    resetn = 1'b1;

    //   st vl ab  sel rdy bsy dn srn ia da   (outputs after the edge)
    add(1, 0, 0,   0,  0,  1,  0, 0,  0, 0);
    add(0, 1, 0,   0,  1,  1,  0, 0,  0, 0);
    add(0, 1, 0,   0,  1,  1,  0, 0,  0, 0);
    add(0, 1, 0,   0,  1,  1,  0, 0,  1, 0);
    add(0, 1, 0,   0,  1,  1,  0, 0,  2, 0);
    add(0, 1, 0,   0,  1,  1,  0, 0,  3, 0);
    add(0, 1, 0,   0,  1,  1,  0, 0,  3, 0);
    add(0, 1, 0,   1,  0,  1,  0, 0,  3, 1);
    add(0, 1, 0,   1,  1,  1,  0, 0,  3, 1);
    add(0, 1, 0,   1,  1,  1,  0, 0,  0, 1);
    add(0, 1, 0,   1,  1,  1,  0, 0,  1, 1);
    add(0, 1, 0,   1,  1,  1,  0, 0,  2, 1);
    add(0, 1, 0,   1,  1,  1,  0, 0,  3, 1);
    add(0, 1, 0,   1,  1,  1,  0, 0,  3, 0);
    add(0, 1, 0,   9,  0,  1,  0, 0,  3, 1);
    add(0, 1, 0,   9,  0,  1,  0, 0,  3, 1);
    add(0, 1, 0,   9,  0,  0,  1, 1,  3, 1);
    add(0, 0, 0,   9,  0,  0,  1, 1,  3, 1);

    for (int i = 0; i < tv.size(); i++) begin
      start = (tv[i].st != 0); in_valid = (tv[i].vl != 0); abort = (tv[i].ab != 0);
      in_data = 32'hD000_0000 + 32'(i);
      step();
      chk($sformatf("tbl[%0d].sel", i),   32'(processor_select), tv[i].sel);
      chk($sformatf("tbl[%0d].rdy", i),   32'(in_ready),         tv[i].rdy);
      chk($sformatf("tbl[%0d].busy", i),  32'(busy),             tv[i].bsy);
      chk($sformatf("tbl[%0d].done", i),  32'(done),             tv[i].dn);
      chk($sformatf("tbl[%0d].srn", i),   32'(sys_resetn),       tv[i].srn);
      chk($sformatf("tbl[%0d].iaddr", i), 32'(boot_iaddr),       tv[i].ia);
      chk($sformatf("tbl[%0d].daddr", i), 32'(boot_daddr),       tv[i].da);
    end
    start = 1'b0; in_valid = 1'b0;

    // in_valid toggling every cycle
    start = 1'b1; step(); check_model("tog"); start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      in_valid = c[0]; in_data = $urandom;
      step(); check_model("tog");
      if (done) break;
    end
    chk("tog.finished", 32'(done), 32'd1);
    in_valid = 1'b0;

    // abort while word 2 of the instruction image is on offer
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; step();
    in_data = 32'hA0A0_0000; step();
    in_data = 32'hA0A0_0001; d1 = in_data; step();
    in_data = 32'hA0A0_0002; abort = 1'b1; step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort.iaddr", 32'(boot_iaddr), 32'd1);
    chk("abort.idata", boot_idata,      d1);
    chk("abort.busy",  32'(busy),       32'd0);
    chk("abort.sel",   32'(processor_select), 32'(IS));
    chk("abort.srn",   32'(sys_resetn), 32'd0);
    chk("abort.rdy",   32'(in_ready),   32'd0);
    check_model("abort");
    step(); check_model("abort.idle");

    // reset pulse during data load of processor 1
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1;
    repeat (13) begin in_data = $urandom; step(); check_model("pre"); end
    chk("midrst.pre.sel", 32'(processor_select), 32'd1);
    #2 resetn = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk); resetn = 1'b1; in_valid = 1'b0;
    step(); chk_reset("midrst.wait");
    start = 1'b1; step(); start = 1'b0; check_model("reload");
    in_valid = 1'b1; step(); check_model("reload");
    d0 = 32'h5EED_0000; in_data = d0; step(); check_model("reload");
    chk("reload.sel",   32'(processor_select), 32'd0);
    chk("reload.iaddr", 32'(boot_iaddr),       32'd0);
    chk("reload.idata", boot_idata,            d0);
    for (int c = 0; c < 40 && !done; c++) begin in_data = $urandom; step(); check_model("reload"); end
    chk("reload.finished", 32'(done), 32'd1);

    // two back-to-back passes; the first gets a stray start during LOAD_I
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1; in_valid = 1'b0; step(); check_model("pass");
      cnt = 1; in_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
        start = (pass == 0 && cnt == 3);
        in_data = $urandom;
        step(); cnt++; check_model("pass");
        if (done) break;
      end
      start = 1'b0;
      chk($sformatf("pass%0d.len", pass), 32'(cnt), 32'd17);
    end
    in_valid = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 15) == 0);
      abort    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 99) < 65);
      in_data  = $urandom;
      step();
      check_model("rnd");
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter NUM_PROC, default 9, number of processors in the mesh (1..9).
REQ-002 SHALL have parameter IMEM_WORDS, default 4096, instruction words loaded per processor (1..16384).
REQ-003 SHALL have parameter DMEM_WORDS, default 4096, data words loaded per processor (1..16384).
REQ-004 SHALL have parameter IDLE_SEL, default 9, the processor_select code that disables all boot write enables.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle pulse, begins a boot pass when idle or done.
REQ-008 abort  input  1  aborts a boot pass in progress.
REQ-009 in_valid  input  1  image word available.
REQ-010 in_data  input  32  image word.
REQ-011 in_ready  output  1  word accepted when in_valid && in_ready at a rising edge.
REQ-012 processor_select  output  4  processor whose boot enables are active.
REQ-013 boot_iaddr  output  14  instruction-memory word address.
REQ-014 boot_idata  output  32  instruction word.
REQ-015 boot_daddr  output  14  data-memory word address.
REQ-016 boot_ddata  output  32  data word.
REQ-017 sys_resetn  output  1  reset driven to the processor mesh; low while loading.
REQ-018 busy  output  1  boot pass in progress.
REQ-019 done  output  1  boot pass completed; mesh released.

Function
REQ-020 SHALL implement states IDLE, SETUP, LOAD_I, LOAD_D, RELEASE, DONE.
REQ-021 IDLE: processor_select=IDLE_SEL, sys_resetn=0, in_ready=0, busy=0; start -> SETUP with processor index p=0.
REQ-022 SETUP: processor_select=p, in_ready=0, exactly 1 cycle, then -> LOAD_I with word counter 0 (covers the mesh's one-cycle registered enable).
REQ-023 LOAD_I: in_ready=1; each accepted word k registers boot_iaddr=k, boot_idata=in_data on the accepting edge; after word IMEM_WORDS-1 accepted -> LOAD_D, counter 0.
REQ-024 LOAD_D: in_ready=1; each accepted word k registers boot_daddr=k, boot_ddata=in_data; after word DMEM_WORDS-1: if p<NUM_PROC-1, p+1 and -> SETUP, else -> RELEASE.
REQ-025 Address/data outputs SHALL hold their last value until the next accepted word of the same kind (repeated writes of a stable word are harmless).
REQ-026 in_valid=0 in LOAD_I/LOAD_D SHALL stall with no counter or output change; no bubble cycles when in_valid stays high.
REQ-027 RELEASE: processor_select=IDLE_SEL, sys_resetn=0, in_ready=0, 2 cycles, then -> DONE.
REQ-028 DONE: sys_resetn=1, done=1, busy=0, processor_select=IDLE_SEL; start -> SETUP with p=0, done=0, sys_resetn=0 on the same edge.
REQ-029 busy SHALL be 1 in SETUP, LOAD_I, LOAD_D, RELEASE.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort while busy SHALL -> IDLE on the next edge, dropping any word offered that cycle (in_ready low from then); abort takes priority over acceptance; abort in IDLE/DONE ignored.
REQ-032 Counters SHALL be 14 bits plus terminal compare; no wrap-around beyond IMEM_WORDS-1/DMEM_WORDS-1.
REQ-033 in_ready SHALL be a registered function of state only, never of in_valid.

Reset
REQ-034 resetn low SHALL asynchronously force IDLE, p=0, counters 0, processor_select=IDLE_SEL, sys_resetn=0, in_ready=0, busy=0, done=0, all boot address/data outputs 0.
REQ-035 Reset asserted mid-pass SHALL abandon the pass; after deassertion the block waits for start.

Verification
REQ-036 NUM_PROC=2, IMEM_WORDS=4, DMEM_WORDS=2, in_valid held 1, start -> select 0 for 1+4+2 cycles then select 1, iaddr 0..3, daddr 0..1 per processor, done=1 and sys_resetn=1 exactly 2 cycles after last word.
REQ-037 Same params, in_valid toggled 1/0 each cycle -> every word accepted once in order, counters frozen on in_valid=0 cycles.
REQ-038 abort asserted with in_valid=1 during LOAD_I word 2 -> word not accepted, next cycle IDLE, busy=0, select=9, sys_resetn=0.
REQ-039 resetn pulsed low during LOAD_D of processor 1 -> outputs at reset values immediately; new start reloads from processor 0, address 0.
REQ-040 start pulsed during LOAD_I -> no effect; start in DONE -> done=0, sys_resetn=0, full second pass with identical output sequence.
